vreg_store_serializer: RTL and testbench

//  Vector store engine. Reads one whole 256-bit vector register through a

---
 rtl/vreg_store_serializer.sv | 103 ++++++++++
 tb/tb_vreg_store_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_store_serializer.sv
// Vector store engine: snapshots one full vector register on command acceptance
// and streams its elements to the data-memory write port, one per handshake.
module vreg_store_serializer #(
  parameter int ELEMS = 16,
  parameter int EW    = 16,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_vreg,
  input  logic [4:0]          cmd_len,
  input  logic [AW-1:0]       cmd_base,
  output logic [3:0]          rAddr,
  input  logic [ELEMS*EW-1:0] rData,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [AW-1:0]       mem_addr,
  output logic [EW-1:0]       mem_data,
  output logic                mem_last,
  output logic                busy,
  output logic                done
);

  localparam int IW = $clog2(ELEMS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx;
  logic [4:0]          len_q;
  logic [4:0]          len_clamp;
  logic [AW-1:0]       base_q;
  logic [3:0]          vreg_q;
  logic [ELEMS*EW-1:0] snap;
  logic                accept;
  logic                is_last;

  assign len_clamp = (cmd_len > 5'(ELEMS)) ? 5'(ELEMS) : cmd_len;
  assign accept    = (state == S_IDLE) && cmd_valid;
  assign is_last   = ({1'b0, idx} == (len_q - 5'd1));
  assign busy      = (state != S_IDLE);
  assign rAddr     = (state == S_IDLE) ? cmd_vreg : vreg_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      len_q  <= '0;
      base_q <= '0;
      vreg_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        len_q  <= len_clamp;
        base_q <= cmd_base;
        vreg_q <= cmd_vreg;
        idx    <= '0;
      end else if (state == S_SEND && mem_ready && !is_last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // NOTE: the snapshot is pure datapath, only ever read in SEND after a load,
  // so it carries no reset and stays a plain register array.
  always_ff @(posedge clk) begin
    if (accept) snap <= rData;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    mem_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = (len_clamp == 5'd0) ? S_DONE : S_SEND;
      end
      S_SEND: begin
        mem_valid = 1'b1;
        mem_addr  = base_q + AW'(idx);
        mem_data  = snap[int'(idx)*EW +: EW];
        mem_last  = is_last;
        if (mem_ready && is_last) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vreg_store_serializer.sv
// Self-checking bench: table of store commands plus reset/snapshot sequences,
// memory beats checked against a scoreboard queue filled at command issue.
module tb_vreg_store_serializer;

  localparam int ELEMS = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int DW    = ELEMS * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_vreg;
  logic [4:0]    cmd_len;
  logic [AW-1:0] cmd_base;
  logic [3:0]    rAddr;
  logic [DW-1:0] rData;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] mem_data;
  logic          mem_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  vreg_store_serializer #(.ELEMS(ELEMS), .EW(EW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vreg(cmd_vreg),
    .cmd_len(cmd_len), .cmd_base(cmd_base),
    .rAddr(rAddr), .rData(rData),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_last(mem_last),
    .busy(busy), .done(done)
  );

  // Register file model: writes land on the clock edge, reads are immediate.
  logic [DW-1:0] rf [16];
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign rData = rf[rAddr];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0]  vreg;
    logic [4:0]  len;
    logic [15:0] base;
    int          mode;       // 0 ready high, 1 toggling, 2 random
    int          exp_beats;
  } vec_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    beat_cnt = 0;
  int    ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int r);
    logic [DW-1:0] v;
    for (int e = 0; e < ELEMS; e++)
      v[e*EW +: EW] = (r == 3) ? 16'(e) : {4'(r), 4'hA, 8'(e)};
    return v;
  endfunction

  task automatic rf_write(input logic [3:0] r, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = r; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       mem_ready = ~mem_ready;
        2:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard compare on each handshake, stall stability otherwise.
  initial begin
    beat_t cur, prev, e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{mem_addr, mem_data, mem_last};
        if (prev_stall) begin
          check("stall_valid_held", 64'(mem_valid), 64'd1);
          check("stall_beat_held", 64'(cur), 64'(prev));
        end
        if (mem_valid && mem_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(mem_addr), 64'(e.addr));
            check("beat_data", 64'(mem_data), 64'(e.data));
            check("beat_last", 64'(mem_last), 64'(e.last));
          end
          beat_cnt++;
        end
        prev_stall = mem_valid && !mem_ready;
        prev = cur;
      end
    end
  end

  // Issue one command at posedge+1 and follow it until the done pulse.
  task automatic run_cmd(input vec_t v, input bit snap_wr);
    int  busy_cnt = 0;
    int  done_k = -1;
    bit  got_done = 0;
    beat_t b;
    ready_mode = v.mode;
    for (int i = 0; i < v.exp_beats; i++) begin
      b.addr = v.base + 16'(i);
      b.data = rf[v.vreg][i*EW +: EW];
      b.last = (i == v.exp_beats - 1);
      exp_q.push_back(b);
    end
    beat_cnt = 0;
    cmd_valid = 1'b1; cmd_vreg = v.vreg; cmd_len = v.len; cmd_base = v.base;
    if (snap_wr) begin
      wr_en = 1'b1; wr_addr = v.vreg; wr_data = ~rf[v.vreg];
    end
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    check("raddr_idle", 64'(rAddr), 64'(v.vreg));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (snap_wr) wr_data = {16{16'hBEEF}};
    for (int k = 0; k < 200 && !got_done; k++) begin
      @(negedge clk); #1;
      if (snap_wr && k == 0) wr_en = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin got_done = 1; done_k = k; end
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("beat_count", 64'(beat_cnt), 64'(v.exp_beats));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (v.mode == 0) begin
      check("done_latency", 64'(done_k), 64'(v.exp_beats));
      check("busy_cycles", 64'(busy_cnt), 64'(v.exp_beats + 1));
    end
    @(negedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("back_to_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[7];
    vec_t sv;
    vecs[0] = '{vreg: 4'd3,  len: 5'd16, base: 16'h0100, mode: 0, exp_beats: 16};
    vecs[1] = '{vreg: 4'd5,  len: 5'd4,  base: 16'h2000, mode: 1, exp_beats: 4};
    vecs[2] = '{vreg: 4'd7,  len: 5'd0,  base: 16'h1234, mode: 0, exp_beats: 0};
    vecs[3] = '{vreg: 4'd9,  len: 5'd20, base: 16'h0040, mode: 0, exp_beats: 16};
    vecs[4] = '{vreg: 4'd1,  len: 5'd1,  base: 16'h0500, mode: 0, exp_beats: 1};
    vecs[5] = '{vreg: 4'd12, len: 5'd4,  base: 16'hFFFE, mode: 0, exp_beats: 4};
    vecs[6] = '{vreg: 4'd15, len: 5'd7,  base: 16'h8000, mode: 2, exp_beats: 7};

    rst = 1'b1; cmd_valid = 1'b0; cmd_vreg = 4'hA; cmd_len = '0; cmd_base = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_last", 64'(mem_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_raddr", 64'(rAddr), 64'hA);
    for (int r = 0; r < 16; r++) rf_write(4'(r), init_val(r));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i], 1'b0);

    // Snapshot: v3 rewritten on the acceptance edge and again during SEND.
    sv = '{vreg: 4'd3, len: 5'd8, base: 16'h0300, mode: 1, exp_beats: 8};
    run_cmd(sv, 1'b1);

    // Reset in the middle of a full store, while element 5 is on the bus.
    ready_mode = 0;
    rf_write(4'd3, init_val(3));
    for (int i = 0; i < 16; i++) exp_q.push_back('{16'h0100 + 16'(i), 16'(i), i == 15});
    beat_cnt = 0;
    cmd_valid = 1'b1; cmd_vreg = 4'd3; cmd_len = 5'd16; cmd_base = 16'h0100;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin @(negedge clk); #1; end
    check("pre_rst_addr", 64'(mem_addr), 64'h0105);
    check("pre_rst_beats", 64'(beat_cnt), 64'd6);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("post_rst_mem_valid", 64'(mem_valid), 64'd0);
      check("post_rst_done", 64'(done), 64'd0);
      check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
